reset_sequencer: RTL and testbench

Parametrised board-level reset controller between the clock PLL and the SoC. It synchronises the PLL lock flag and a raw reset push-button, and debounces the button. It holds a vector of active-high reset outputs asserted until lock is stable, then releases them one at a time in a fixed staggered order. It replaces the ad-hoc lock/button gating in each board top with one reusable block that also reports button events.

---
 rtl/reset_pkg.sv | 19 +
 rtl/button_filter.sv | 66 ++++++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reset_pkg : shared types and helpers for the reset sequencer       |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rstseq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | button_filter : button synchroniser, debounce filter, press edge   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module button_filter #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic button_in,
    output logic filtered_out,
    output logic press_out,
    output logic press_next_out
);

    localparam int              c_dw      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_dw-1:0] c_db_last = c_dw'(DEBOUNCE_CYCLES - 1);

    logic            w_btn_fixed;
    logic            w_toggle;
    logic [1:0]      sync_q, sync_d;
    logic            filt_q, filt_d;
    logic [c_dw-1:0] cnt_q, cnt_d;
    logic            evt_q, evt_d;

    // 1 = pressed after this point, so the all-zero reset state reads as released
    assign w_btn_fixed = BTN_ACTIVE_HIGH ? button_in : ~button_in;

    always_comb begin
        sync_d   = {sync_q[0], w_btn_fixed};
        filt_d   = filt_q;
        cnt_d    = '0;
        w_toggle = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == c_db_last) begin
                w_toggle = 1'b1;
                filt_d   = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        evt_d = w_toggle & ~filt_q;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            evt_q  <= evt_d;
        end
    end

    assign filtered_out   = filt_q;
    assign press_out      = evt_q;
    assign press_next_out = evt_d;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reset_sequencer : lock/button gated, staggered reset release       |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_OUTPUTS     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   locked_in,
    input  logic                   button_in,
    output logic [NUM_OUTPUTS-1:0] resets_out,
    output logic                   ready_out,
    output logic                   button_event_out
);

    localparam int              c_cw        = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
    localparam int              c_iw        = $clog2(NUM_OUTPUTS + 1);
    localparam logic [c_cw-1:0] c_hold_last = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0] c_stag_last = c_cw'(STAGGER_CYCLES - 1);
    localparam logic [c_iw-1:0] c_last_idx  = c_iw'(NUM_OUTPUTS - 1);

    logic                   w_filtered;
    logic                   w_press_next;
    logic                   w_locked_s;
    logic                   w_hold;
    logic [1:0]             lock_sync_q, lock_sync_d;
    rstseq_state_t          state_q, state_d;
    logic [c_cw-1:0]        cnt_q, cnt_d;
    logic [c_iw-1:0]        idx_q, idx_d;
    logic [NUM_OUTPUTS-1:0] resets_q, resets_d;
    logic                   ready_q, ready_d;

    button_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_HIGH (BTN_ACTIVE_HIGH)
    ) u_button_filter (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .button_in      (button_in),
        .filtered_out   (w_filtered),
        .press_out      (button_event_out),
        .press_next_out (w_press_next)
    );

    assign lock_sync_d = {lock_sync_q[0], locked_in};
    assign w_locked_s  = lock_sync_q[1];
    assign w_hold      = w_locked_s & ~w_filtered;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        resets_d = resets_q;
        ready_d  = ready_q;
        // A fresh press is seen on the edge it is filtered, so the abort lines up with the event pulse
        if (!w_locked_s || w_press_next) begin
            state_d  = ST_ASSERT;
            resets_d = '1;
            ready_d  = 1'b0;
            cnt_d    = '0;
            idx_d    = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    resets_d = '1;
                    ready_d  = 1'b0;
                    if (!w_hold) begin
                        cnt_d = '0;
                    end else if (cnt_q == c_hold_last) begin
                        resets_d[0] = 1'b0;
                        cnt_d       = '0;
                        idx_d       = c_iw'(1);
                        if (NUM_OUTPUTS == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == c_stag_last) begin
                        cnt_d = '0;
                        for (int k = 0; k < NUM_OUTPUTS; k++) begin
                            if (idx_q == c_iw'(k)) resets_d[k] = 1'b0;
                        end
                        idx_d = idx_q + 1'b1;
                        if (idx_q == c_last_idx) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    resets_d = '0;
                    ready_d  = 1'b1;
                    cnt_d    = '0;
                end
                default: begin
                    state_d  = ST_ASSERT;
                    resets_d = '1;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            lock_sync_q <= '0;
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            resets_q    <= '1;
            ready_q     <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            resets_q    <= resets_d;
            ready_q     <= ready_d;
        end
    end

    assign resets_out = resets_q;
    assign ready_out  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reset_sequencer : scoreboard bench for reset_sequencer          |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_reset_sequencer;

    localparam int c_n = 3;

    logic           clk_in;
    logic           reset_in;
    logic           locked_in;
    logic           button_in;
    logic [c_n-1:0] resets_out;
    logic           ready_out;
    logic           button_event_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int       edge_no;
        logic [2:0] rst;
        logic     rdy;
        logic     evt;
        string    tag;
    } exp_t;

    exp_t sb[$];

    reset_sequencer #(
        .NUM_OUTPUTS     (c_n),
        .HOLD_CYCLES     (4),
        .STAGGER_CYCLES  (2),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .locked_in        (locked_in),
        .button_in        (button_in),
        .resets_out       (resets_out),
        .ready_out        (ready_out),
        .button_event_out (button_event_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int e, input logic [2:0] r, input logic rd, input logic ev, input string tag);
        exp_t x;
        x.edge_no = e;
        x.rst     = r;
        x.rdy     = rd;
        x.evt     = ev;
        x.tag     = tag;
        sb.push_back(x);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk_in);
    endtask

    // Bit j released once k reaches first_rel + 2*j (stagger of 2)
    function automatic logic [2:0] rel_bits(input int k, input int first_rel);
        logic [2:0] r;
        r = 3'b111;
        for (int j = 0; j < 3; j++) if (k >= first_rel + 2 * j) r[j] = 1'b0;
        return r;
    endfunction

    always @(negedge clk_in) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, {27'd0, resets_out, ready_out, button_event_out},
                {27'd0, e.rst, e.rdy, e.evt});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [2:0] r;
        reset_in  = 1'b1;
        locked_in = 1'b1;
        button_in = 1'b0;
        #3;
        chk("rst_resets", {29'd0, resets_out}, 32'h7);
        chk("rst_ready", {31'd0, ready_out}, 32'h0);
        chk("rst_event", {31'd0, button_event_out}, 32'h0);
        repeat (3) @(negedge clk_in);

        // power-up
        reset_in = 1'b0;
        t = cyc;
        for (int k = 1; k <= 12; k++) begin
            r = rel_bits(k, 6);
            push(t + k, r, (r == 3'b000), 1'b0, "pwrup");
        end
        goto(t + 12);

        // short glitch in RUN is filtered out
        t = cyc;
        button_in = 1'b1;
        for (int k = 1; k <= 10; k++) push(t + k, 3'b000, 1'b1, 1'b0, "glitch");
        goto(t + 3);
        button_in = 1'b0;
        goto(t + 10);

        // real press in RUN, then release and restart
        t = cyc;
        button_in = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            if (k < 6) push(t + k, 3'b000, 1'b1, 1'b0, "press");
            else begin
                r = rel_bits(k, 22);
                push(t + k, r, (r == 3'b000), (k == 6), "press");
            end
        end
        goto(t + 12);
        button_in = 1'b0;
        goto(t + 27);

        // late lock: 20 cycles without lock
        t = cyc;
        locked_in = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (k < 3) push(t + k, 3'b000, 1'b1, 1'b0, "latelock");
            else begin
                r = rel_bits(k, 26);
                push(t + k, r, (r == 3'b000), 1'b0, "latelock");
            end
        end
        goto(t + 20);
        locked_in = 1'b1;
        goto(t + 31);

        // one-cycle lock loss in RUN, then again mid-release
        t = cyc;
        locked_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k < 3)       push(t + k, 3'b000, 1'b1, 1'b0, "lockloss");
            else if (k < 11) begin
                r = rel_bits(k, 7);
                push(t + k, r, (r == 3'b000), 1'b0, "lockloss");
            end else begin
                r = rel_bits(k, 15);
                push(t + k, r, (r == 3'b000), 1'b0, "lockloss_mid");
            end
        end
        goto(t + 1);
        locked_in = 1'b1;
        goto(t + 8);
        locked_in = 1'b0;
        goto(t + 9);
        locked_in = 1'b1;
        goto(t + 20);

        // lock loss and press land on the same edge
        t = cyc;
        button_in = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            if (k < 6) push(t + k, 3'b000, 1'b1, 1'b0, "simul");
            else begin
                r = rel_bits(k, 18);
                push(t + k, r, (r == 3'b000), (k == 6), "simul");
            end
        end
        goto(t + 3);
        locked_in = 1'b0;
        goto(t + 4);
        locked_in = 1'b1;
        goto(t + 8);
        button_in = 1'b0;
        goto(t + 23);

        // asynchronous reset between edges
        #2;
        reset_in = 1'b1;
        #1;
        chk("async_resets", {29'd0, resets_out}, 32'h7);
        chk("async_ready", {31'd0, ready_out}, 32'h0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
